// File: rtl/reg_scan_reader_pkg.sv
// Shared constants, FSM state type and bank-slice helper for the register scan reader.
package cute_pkg;

    localparam int DATA_W    = 9;
    localparam int IDX_W     = 3;
    localparam int BANK_REGS = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } scan_state_t;

    // Register k of a flattened default-geometry bank.
    function automatic logic [DATA_W-1:0] reg_slice(
        input logic [BANK_REGS*DATA_W-1:0] flat,
        input logic [IDX_W-1:0]            k
    );
        return flat[k*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/reg_scan_reader_mux.sv
// Combinational NUM_REGS:1 selector returning register 'sel' from a flattened bank.
module reg_scan_mux #(
    parameter int NUM_REGS = cute_pkg::BANK_REGS,
    parameter int DATA_W   = cute_pkg::DATA_W,
    parameter int IDX_W    = cute_pkg::IDX_W
) (
    input  logic [NUM_REGS*DATA_W-1:0] bank,
    input  logic [IDX_W-1:0]           sel,
    output logic [DATA_W-1:0]          data
);

    always_comb begin
        data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (sel == IDX_W'(k)) begin
                data = bank[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/reg_scan_reader.sv
// Reads one register or scans the whole bank onto a valid/ready stream.
// Optional REG_SCAN_SNAPSHOT_EN serves every value of a command from a bank image taken at start.
module reg_scan_reader #(
    parameter int NUM_REGS = cute_pkg::BANK_REGS,
    parameter int DATA_W   = cute_pkg::DATA_W,
    parameter int IDX_W    = cute_pkg::IDX_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       single,
    input  logic [IDX_W-1:0]           idx,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic signed [DATA_W-1:0]   out_data,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
);

    import cute_pkg::*;

    scan_state_t               state;
    logic [IDX_W-1:0]          cur;
    logic                      single_r;
    logic [IDX_W-1:0]          first_idx;
    logic [IDX_W-1:0]          next_idx;
    logic [IDX_W-1:0]          mux_sel;
    logic                      last;
    logic                      first_ok;
    logic [NUM_REGS*DATA_W-1:0] mux_bank;
    logic [DATA_W-1:0]         mux_data;

    assign first_idx = single ? idx : '0;
    assign first_ok  = !single || (int'(idx) < NUM_REGS);
    assign next_idx  = cur + IDX_W'(1);
    assign last      = single_r || (cur == IDX_W'(NUM_REGS - 1));
    // In IDLE the mux looks at the first index of a new command, otherwise at the next one.
    assign mux_sel   = (state == IDLE) ? first_idx : next_idx;

`ifdef REG_SCAN_SNAPSHOT_EN
    logic [NUM_REGS*DATA_W-1:0] snap;

    always_ff @(posedge clk) begin
        if (reset) begin
            snap <= '0;
        end else if (state == IDLE && start) begin
            snap <= regs_flat;
        end
    end

    // The snapshot is captured on the start edge, so the first value still comes from the live bank.
    assign mux_bank = (state == IDLE) ? regs_flat : snap;
`else
    assign mux_bank = regs_flat;
`endif

    reg_scan_mux #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_mux (
        .bank (mux_bank),
        .sel  (mux_sel),
        .data (mux_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur       <= '0;
            single_r  <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        single_r <= single;
                        cur      <= first_idx;
                        busy     <= 1'b1;
                        if (first_ok) begin
                            out_data  <= mux_data;
                            out_idx   <= first_idx;
                            out_valid <= 1'b1;
                            state     <= SEND;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cur      <= next_idx;
                            out_data <= mux_data;
                            out_idx  <= next_idx;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
